alu_cmd_issuer: RTL
===================

Name: alu_cmd_issuer

Overview:
Requester-side controller for the 4-bit combinational ALU (operands a/b, 3-bit select, 5-bit out). It accepts operation requests on a valid/ready channel and drives the ALU operand/select lines. After a programmable settle time it captures the ALU output and returns it on a valid/ready response channel. It traps divide/modulo by zero without issuing the operation, and keeps a count of completed operations.

Parameters:
DATA_W, 4, operand width; must match the ALU a/b width.
RES_W, 5, result width; must match the ALU out width.
SEL_W, 3, opcode width; must match the ALU select width.
SETTLE_CYCLES, 1, cycles alu_* is held stable before alu_out is sampled; legal range 1..15.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  issuer can accept a request.
req_a  in  DATA_W  operand A.
req_b  in  DATA_W  operand B.
req_op  in  SEL_W  opcode, same encoding as the ALU select.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  RES_W  captured ALU result; 0 when rsp_err is 1.
rsp_err  out  1  1 means divide/modulo by zero was trapped.
alu_a  out  DATA_W  drives ALU a.
alu_b  out  DATA_W  drives ALU b.
alu_select  out  SEL_W  drives ALU select.
alu_out  in  RES_W  ALU result, combinational from alu_*.
busy  out  1  high in any state other than IDLE.
op_count  out  CNT_W  number of completed response handshakes; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_select=0.
  - op_count=0, busy=0.
  - Any in-flight request is dropped.
- Opcodes: 000 pass A, 001 add, 010 sub, 011 div, 100 mod, 101 shl1, 110 shr1, 111 A>B.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register req_a, req_b and req_op into alu_a, alu_b and alu_select.
  - If req_op is 011 or 100 and req_b==0: go to RESP with rsp_err=1 and rsp_data=0.
  - Otherwise: load settle_cnt=SETTLE_CYCLES and go to DRIVE.
- DRIVE:
  - req_ready=0.
  - alu_* are held constant.
  - If settle_cnt==1: rsp_data<=alu_out, rsp_err<=0, go to RESP.
  - Otherwise: decrement settle_cnt.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_data and rsp_err are held stable until rsp_ready=1 at a clock edge.
  - On that handshake: op_count increments (saturating), rsp_valid falls, state goes to IDLE.
  - There is no IDLE bypass, so the next request is accepted at the earliest one cycle after the response handshake.
- Latency, measured from the request accept edge to the first cycle with rsp_valid high:
  - Normal operations: SETTLE_CYCLES+1 cycles.
  - Trapped divide/modulo by zero: 1 cycle.
- alu_* hold their last issued values through RESP and IDLE. They change only at a request accept edge, so the ALU never sees spurious operand transitions.
- req_valid while req_ready=0 is ignored; upstream must hold the request until it is accepted.
- rsp_ready asserted while rsp_valid=0 has no effect.
- rsp_data is sampled as a full RES_W bits with no truncation. The ALU owns the arithmetic: subtraction wraps mod 2^RES_W and shl1 keeps its carry bit.
- Unknown opcodes cannot occur because all 8 encodings are defined.
- busy is 1 exactly when state is not IDLE.

Decomposition:
- Package alu_pkg holds:
  - Opcode localparams: OP_PASS, OP_ADD, OP_SUB, OP_DIV, OP_MOD, OP_SHL, OP_SHR, OP_GT.
  - DATA_W, RES_W and SEL_W defaults.
  - State encoding: IDLE=2'd0, DRIVE=2'd1, RESP=2'd2.
- No sub-module in the RTL; the FSM and datapath stay in one module.
- The bench instantiates the existing ALU as the alu_* peer.

Test Plan:
1. Add: req a=7, b=5, op=001, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=12, rsp_err=0, op_count=1.
2. Sub wrap and shift: a=3, b=5, op=010 → rsp_data=30. Then a=4'b1001, op=101 → rsp_data=18.
3. Divide by zero: a=9, b=0, op=011 → rsp_valid next cycle, rsp_err=1, rsp_data=0, alu_select=011. Then a=9, b=4, op=100 → rsp_data=1, rsp_err=0.
4. Backpressure:
   - Set a=5, b=3, op=111 and hold rsp_ready=0 for 5 cycles → rsp_valid stays high, rsp_data=1 stable, req_ready=0.
   - Drive a new req_valid during the hold → it is ignored.
   - Release rsp_ready → return to IDLE; op_count increments once.
5. Settle and reset: SETTLE_CYCLES=3 → rsp_valid 4 cycles after accept. Assert rst while in DRIVE → next cycle state is IDLE, rsp_valid=0, alu_*=0, op_count=0.
6. Saturation: complete 260 back-to-back operations → op_count=255 and holds.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings, default widths and issuer state encoding for the 4-bit ALU.
package alu_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int RES_W_DEF = 5;
  localparam int SEL_W_DEF = 3;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_GT = 3'b111;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRIVE = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: issues requests to a combinational ALU, waits a settle time, returns the result.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W = RES_W_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [SEL_W-1:0]  req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_select,
  input  logic [RES_W-1:0]  alu_out,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
  state_t r_state, w_next;
  logic [3:0] r_settle;
  logic [DATA_W-1:0] r_a, r_b;
  logic [SEL_W-1:0] r_sel;
  logic [RES_W-1:0] r_data;
  logic r_err;
  logic [CNT_W-1:0] r_cnt;
  logic w_trap, w_accept, w_done, w_hs;
  // Zero divisor is trapped before the ALU ever computes it.
  assign w_trap = (req_op == SEL_W'(OP_DIV) || req_op == SEL_W'(OP_MOD)) && req_b == '0;
  assign w_accept = r_state == IDLE && req_valid;
  assign w_done = r_state == DRIVE && r_settle == 4'd1;
  assign w_hs = r_state == RESP && rsp_ready;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = w_trap ? RESP : DRIVE;
    else if (w_done) w_next = RESP;
    else if (w_hs) w_next = IDLE;
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_sel <= '0;
      r_settle <= '0;
      r_data <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_a <= req_a;
        r_b <= req_b;
        r_sel <= req_op;
        r_settle <= SETTLE_INIT;
        if (w_trap) begin
          r_data <= '0;
          r_err <= 1'b1;
        end
      end
      if (r_state == DRIVE) r_settle <= r_settle - 4'd1;
      if (w_done) begin
        r_data <= alu_out;
        r_err <= 1'b0;
      end
      if (w_hs && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign busy = r_state != IDLE;
  assign rsp_data = r_data;
  assign rsp_err = r_err;
  assign alu_a = r_a;
  assign alu_b = r_b;
  assign alu_select = r_sel;
  assign op_count = r_cnt;
endmodule
